// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, write-back and ALU-op encodings plus the decoded control bundle
// used by the ID stage controller.
package cpu_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       jalr_sel;
    logic       csr_read;
    logic       alu_src1_is_pc;
    logic [1:0] alu_op;
    logic [1:0] wb_src;
  } ctrl_t;

  function automatic logic is_known_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OPIMM,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: raw instruction to control bundle and register-use flags.
// The illegal output exists only when CPU_CTRL_ILLEGAL_TRAP_EN is defined.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        use_rs1,
  output logic        use_rs2
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  logic [6:0] opcode;
  logic       writes_rd;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign unused_bits = ^instr[31:12];

  always_comb begin
    ctrl      = '0;
    writes_rd = 1'b0;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.wb_src   = WB_MEM;
        writes_rd     = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        use_rs2        = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BRANCH;
        use_rs2     = 1'b1;
      end
      OPC_OP: begin
        ctrl.alu_op = ALUOP_RI;
        writes_rd   = 1'b1;
        use_rs2     = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.alu_op  = ALUOP_RI;
        ctrl.alu_src = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.jump   = 1'b1;
        ctrl.wb_src = WB_PC4;
        writes_rd   = 1'b1;
        use_rs1     = 1'b0;
      end
      OPC_JALR: begin
        ctrl.jump     = 1'b1;
        ctrl.jalr_sel = 1'b1;
        ctrl.wb_src   = WB_PC4;
        writes_rd     = 1'b1;
      end
      OPC_LUI: begin
        ctrl.wb_src = WB_IMM;
        writes_rd   = 1'b1;
        use_rs1     = 1'b0;
      end
      OPC_AUIPC: begin
        ctrl.alu_src1_is_pc = 1'b1;
        writes_rd           = 1'b1;
        use_rs1             = 1'b0;
      end
      OPC_SYSTEM: begin
        ctrl.csr_read = 1'b1;
        ctrl.wb_src   = WB_IMM;
        writes_rd     = 1'b1;
      end
      default: begin
        ctrl.alu_src = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally dropped, so never raise reg_write for them.
    ctrl.reg_write = writes_rd && (instr[11:7] != 5'd0);
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign illegal = !is_known_opcode(opcode) || (instr[1:0] != 2'b11);
`endif

endmodule

// File: rtl/cpu_decode_ctrl.sv
// ID/EX stage controller: valid/ready intake, registered control bundle, flush, stall
// and single-bubble load-use hazard insertion. Optional trap flag via CPU_CTRL_ILLEGAL_TRAP_EN.
module cpu_decode_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [2:0]            out_funct3,
  output logic                  out_branch,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_alu_src,
  output logic                  out_reg_write,
  output logic                  out_jump,
  output logic                  out_jalr_sel,
  output logic                  out_csr_read,
  output logic                  out_alu_src1_is_pc,
  output logic [1:0]            out_alu_op,
  output logic [1:0]            out_wb_src
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  out_illegal
`endif
);

  ctrl_t                  dec_ctrl;
  ctrl_t                  ctrl_q;
  logic                   use_rs1;
  logic                   use_rs2;
  logic [REG_ADDR_W-1:0]  in_rs1;
  logic [REG_ADDR_W-1:0]  in_rs2;
  logic [REG_ADDR_W-1:0]  in_rd;
  logic                   advance;
  logic                   hazard;
  logic                   load_now;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic dec_illegal;
`endif

  cpu_ctrl_decode u_decode (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal (dec_illegal)
`endif
  );

  assign in_rs1 = REG_ADDR_W'(in_instr[19:15]);
  assign in_rs2 = REG_ADDR_W'(in_instr[24:20]);
  assign in_rd  = REG_ADDR_W'(in_instr[11:7]);

  // rs2 is checked even for stores: no store-data forwarding, so the store waits too.
  assign advance  = !out_valid || ex_ready;
  assign hazard   = out_valid && ctrl_q.mem_read && (out_rd != '0) &&
                    ((use_rs1 && (in_rs1 == out_rd)) || (use_rs2 && (in_rs2 == out_rd)));
  assign in_ready = advance && !hazard && !flush;
  assign load_now = advance && !hazard && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
      out_rd     <= '0;
      out_funct3 <= '0;
      ctrl_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else if (advance) begin
      if (load_now) begin
        out_valid  <= 1'b1;
        out_pc     <= in_pc;
        out_rs1    <= in_rs1;
        out_rs2    <= in_rs2;
        out_rd     <= in_rd;
        out_funct3 <= in_instr[14:12];
        ctrl_q     <= dec_ctrl;
      end else begin
        out_valid <= 1'b0;
        ctrl_q    <= '0;
      end
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_illegal <= 1'b0;
    end else if (advance) begin
      out_illegal <= load_now && dec_illegal;
    end
  end
`endif

  assign out_branch         = ctrl_q.branch;
  assign out_mem_read       = ctrl_q.mem_read;
  assign out_mem_write      = ctrl_q.mem_write;
  assign out_alu_src        = ctrl_q.alu_src;
  assign out_reg_write      = ctrl_q.reg_write;
  assign out_jump           = ctrl_q.jump;
  assign out_jalr_sel       = ctrl_q.jalr_sel;
  assign out_csr_read       = ctrl_q.csr_read;
  assign out_alu_src1_is_pc = ctrl_q.alu_src1_is_pc;
  assign out_alu_op         = ctrl_q.alu_op;
  assign out_wb_src         = ctrl_q.wb_src;

endmodule

// File: tb/tb_cpu_decode_ctrl.sv
// Directed bench for cpu_decode_ctrl with an expected-bundle queue filled on intake
// and drained on EX handshake/flush. Define CPU_CTRL_ILLEGAL_TRAP_EN to cover the trap flag.
module tb_cpu_decode_ctrl;

  localparam int XLEN = 32;
  localparam int RW   = 5;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            flush = 1'b0;
  logic            ex_ready = 1'b1;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [RW-1:0]   out_rs1, out_rs2, out_rd;
  logic [2:0]      out_funct3;
  logic            out_branch, out_mem_read, out_mem_write, out_alu_src, out_reg_write;
  logic            out_jump, out_jalr_sel, out_csr_read, out_alu_src1_is_pc;
  logic [1:0]      out_alu_op, out_wb_src;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic            out_illegal;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [12:0] flags;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  logic [12:0] flags_vec;
  assign flags_vec = {out_branch, out_mem_read, out_mem_write, out_alu_src, out_reg_write,
                      out_jump, out_jalr_sel, out_csr_read, out_alu_src1_is_pc,
                      out_alu_op, out_wb_src};

  cpu_decode_ctrl #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr           (in_instr),
    .in_pc              (in_pc),
    .flush              (flush),
    .ex_ready           (ex_ready),
    .out_valid          (out_valid),
    .out_pc             (out_pc),
    .out_rs1            (out_rs1),
    .out_rs2            (out_rs2),
    .out_rd             (out_rd),
    .out_funct3         (out_funct3),
    .out_branch         (out_branch),
    .out_mem_read       (out_mem_read),
    .out_mem_write      (out_mem_write),
    .out_alu_src        (out_alu_src),
    .out_reg_write      (out_reg_write),
    .out_jump           (out_jump),
    .out_jalr_sel       (out_jalr_sel),
    .out_csr_read       (out_csr_read),
    .out_alu_src1_is_pc (out_alu_src1_is_pc),
    .out_alu_op         (out_alu_op),
    .out_wb_src         (out_wb_src)
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,
    .out_illegal        (out_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Flag order: branch mem_read mem_write alu_src reg_write jump jalr_sel csr_read pc1 alu_op wb
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic wr;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.funct3 = ins[14:12]; e.illegal = 1'b0; wr = 1'b1;
    case (ins[6:0])
      7'b0000011: e.flags = 13'b0_1_0_1_0_0_0_0_0_00_01;
      7'b0100011: begin e.flags = 13'b0_0_1_1_0_0_0_0_0_00_00; wr = 1'b0; end
      7'b1100011: begin e.flags = 13'b1_0_0_0_0_0_0_0_0_01_00; wr = 1'b0; end
      7'b0110011: e.flags = 13'b0_0_0_0_0_0_0_0_0_10_00;
      7'b0010011: e.flags = 13'b0_0_0_1_0_0_0_0_0_10_00;
      7'b1101111: e.flags = 13'b0_0_0_0_0_1_0_0_0_00_10;
      7'b1100111: e.flags = 13'b0_0_0_0_0_1_1_0_0_00_10;
      7'b0110111: e.flags = 13'b0_0_0_0_0_0_0_0_0_00_11;
      7'b0010111: e.flags = 13'b0_0_0_0_0_0_0_0_1_00_00;
      7'b1110011: e.flags = 13'b0_0_0_0_0_0_0_1_0_00_11;
      default: begin
        e.flags = 13'b0_0_0_1_0_0_0_0_0_00_00;
        wr = 1'b0;
        e.illegal = TRAP_EN;
      end
    endcase
    e.flags[8] = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic check_scoreboard();
    checkOutput("sb_valid", {31'd0, out_valid}, (sb.size() != 0) ? 32'd1 : 32'd0);
    if (sb.size() != 0) begin
      checkOutput("sb_pc", out_pc, sb[0].pc);
      checkOutput("sb_rs1", {27'd0, out_rs1}, {27'd0, sb[0].rs1});
      checkOutput("sb_rs2", {27'd0, out_rs2}, {27'd0, sb[0].rs2});
      checkOutput("sb_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
      checkOutput("sb_funct3", {29'd0, out_funct3}, {29'd0, sb[0].funct3});
      checkOutput("sb_flags", {19'd0, flags_vec}, {19'd0, sb[0].flags});
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      checkOutput("sb_illegal", {31'd0, out_illegal}, {31'd0, sb[0].illegal});
`endif
    end else begin
      checkOutput("idle_flags", {19'd0, flags_vec}, 32'd0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      checkOutput("idle_illegal", {31'd0, out_illegal}, 32'd0);
`endif
    end
  endtask

  // One clock: sample handshakes before the edge, update the queue, check at negedge.
  task automatic tick(output logic acc);
    logic fire_out;
    #1;
    fire_out = out_valid && (ex_ready || flush);
    acc      = in_valid && in_ready && rst_n;
    @(posedge clk);
    @(negedge clk);
    if (fire_out && sb.size() != 0) void'(sb.pop_front());
    if (acc) sb.push_back(model(in_instr, in_pc));
    check_scoreboard();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_flags"}, {19'd0, flags_vec}, 32'd0);
    checkOutput({tag, "_pc"}, out_pc, 32'd0);
    checkOutput({tag, "_regs"}, {17'd0, out_rs1, out_rs2, out_rd}, 32'd0);
    checkOutput({tag, "_funct3"}, {29'd0, out_funct3}, 32'd0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    checkOutput({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
`endif
  endtask

  logic [31:0] stream [8] = '{32'h00500113, 32'h00002183, 32'h003101B3, 32'hFE209EE3,
                              32'h00312423, 32'h000280E7, 32'h00000517, 32'h34202573};

  initial begin
    logic acc;
    int   waited;

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // addi x0 -> valid bundle, reg_write suppressed
    applyStimulus(32'h00000013, 32'h100);
    tick(acc);
    checkOutput("addi_x0_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("addi_x0_rw", {31'd0, out_reg_write}, 32'd0);
    checkOutput("addi_x0_aluop", {30'd0, out_alu_op}, 32'd2);

    // Load-use: lw x1 then add x2,x1,x1 -> one bubble
    applyStimulus(32'h00002083, 32'h104);
    tick(acc);
    checkOutput("lw_mem_read", {31'd0, out_mem_read}, 32'd1);
    applyStimulus(32'h00108133, 32'h108);
    #1;
    checkOutput("hazard_ready", {31'd0, in_ready}, 32'd0);
    tick(acc);
    checkOutput("bubble_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post_bubble_ready", {31'd0, in_ready}, 32'd1);
    tick(acc);
    checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add_rd", {27'd0, out_rd}, 32'd2);
    checkOutput("add_rw", {31'd0, out_reg_write}, 32'd1);

    // lw x0 then use of x0 -> no bubble
    applyStimulus(32'h00002003, 32'h10C);
    tick(acc);
    checkOutput("lw_x0_rw", {31'd0, out_reg_write}, 32'd0);
    applyStimulus(32'h00000133, 32'h110);
    #1;
    checkOutput("x0_no_hazard", {31'd0, in_ready}, 32'd1);
    tick(acc);
    checkOutput("x0_use_valid", {31'd0, out_valid}, 32'd1);

    // Load then store of the loaded register as rs2 still stalls
    applyStimulus(32'h00002183, 32'h114);
    tick(acc);
    applyStimulus(32'h00302023, 32'h118);
    #1;
    checkOutput("store_rs2_hazard", {31'd0, in_ready}, 32'd0);
    tick(acc);
    checkOutput("store_bubble", {31'd0, out_valid}, 32'd0);
    tick(acc);
    checkOutput("store_valid", {31'd0, out_mem_write}, 32'd1);

    // Stall: lui x5 held with ex_ready=0, then flush during stall
    applyStimulus(32'h123452B7, 32'h11C);
    tick(acc);
    ex_ready = 1'b0;
    applyStimulus(32'h00100093, 32'h120);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_ready", {31'd0, in_ready}, 32'd0);
      tick(acc);
      checkOutput("stall_rd", {27'd0, out_rd}, 32'd5);
      checkOutput("stall_wb", {30'd0, out_wb_src}, 32'd3);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", {31'd0, in_ready}, 32'd0);
    tick(acc);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // jal then store back to back
    applyStimulus(32'h008000EF, 32'h200);
    tick(acc);
    checkOutput("jal_jump", {31'd0, out_jump}, 32'd1);
    checkOutput("jal_wb", {30'd0, out_wb_src}, 32'd2);
    checkOutput("jal_rd", {27'd0, out_rd}, 32'd1);
    applyStimulus(32'h0020A023, 32'h204);
    tick(acc);
    checkOutput("sw_mem_write", {31'd0, out_mem_write}, 32'd1);
    checkOutput("sw_rw", {31'd0, out_reg_write}, 32'd0);
    checkOutput("sw_alu_src", {31'd0, out_alu_src}, 32'd1);

    // Unknown opcode
    applyStimulus(32'h0000007F, 32'h208);
    tick(acc);
    checkOutput("unk_alu_src", {31'd0, out_alu_src}, 32'd1);
    checkOutput("unk_rw", {31'd0, out_reg_write}, 32'd0);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    applyStimulus(32'hFFFFFFFF, 32'h20C);
    tick(acc);
    checkOutput("trap_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("trap_illegal", {31'd0, out_illegal}, 32'd1);
    checkOutput("trap_side_fx", {24'd0, out_reg_write, out_mem_read, out_mem_write,
                out_branch, out_jump, out_csr_read, 2'b00}, 32'd0);
    applyStimulus(32'h00000013, 32'h210);
    tick(acc);
    checkOutput("trap_clear", {31'd0, out_illegal}, 32'd0);
`endif

    // Mixed stream under random EX back-pressure
    for (int k = 0; k < 8; k++) begin
      applyStimulus(stream[k], 32'h300 + 32'(k * 4));
      waited = 0;
      acc = 1'b0;
      while (!acc) begin
        ex_ready = 1'($urandom_range(0, 1));
        tick(acc);
        waited++;
        if (!acc && waited > 20) begin
          checkOutput("accept_timeout", 32'd0, 32'd1);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    ex_ready = 1'b1;
    tick(acc);
    tick(acc);

    // Asynchronous reset while a bundle is valid
    applyStimulus(32'h00000517, 32'h400);
    tick(acc);
    checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rerst", {31'd0, in_ready}, 32'd1);
    tick(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
